// File: rtl/ternary_fetch_unit.sv
// ternary_fetch_unit -- instruction-fetch front end for the balanced-ternary
// pipeline. Issues one fetch at a time to a variable-latency instruction
// memory, buffers responses in a small prefetch FIFO that feeds decode, and
// handles redirects (with squash of in-flight responses) and a clean halt.
//
// Optional feature: define TERNARY_FETCH_PERF_EN to build the performance
// counters; without it perf_fetches/perf_squashes are tied to zero.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_req / imem_addr       one-cycle fetch request and its address
//   imem_rvalid / imem_rdata   memory response (at least one cycle after req)
//   out_valid/out_ready        decode handshake on the FIFO head
//   out_instr / out_pc         head instruction and its PC
//   redirect_valid/_pc         taken branch/jump from EX/ID
//   halt_req / halted          sticky stop request / fully stopped
//   queue_count                registered FIFO occupancy
//   perf_fetches/_squashes     accepted responses / discarded + flushed
//   dbg_state                  FSM state (IDLE=0, WAIT=1, DRAIN=2, HALT=3)
//
// Handshake: a FIFO entry moves to decode in any cycle where out_valid and
// out_ready are both high at the rising edge; out_valid never depends on
// out_ready, and the head stays stable until it is accepted or flushed.

package ternary_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
endpackage

module ternary_fetch_unit
  import ternary_pkg::*;
#(
  parameter int PC_TRITS    = 8,
  parameter int INSTR_TRITS = 9,
  parameter int QUEUE_DEPTH = 4,
  localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output trit_t [PC_TRITS-1:0]        imem_addr,
  input  logic                        imem_rvalid,
  input  trit_t [INSTR_TRITS-1:0]     imem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output trit_t [INSTR_TRITS-1:0]     out_instr,
  output trit_t [PC_TRITS-1:0]        out_pc,
  input  logic                        redirect_valid,
  input  trit_t [PC_TRITS-1:0]        redirect_pc,
  input  logic                        halt_req,
  output logic                        halted,
  output logic [CNT_W-1:0]            queue_count,
  output logic [31:0]                 perf_fetches,
  output logic [31:0]                 perf_squashes,
  output logic [1:0]                  dbg_state
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef trit_t [PC_TRITS-1:0]    pc_t;
  typedef trit_t [INSTR_TRITS-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Balanced-ternary +1: a +1 trit rolls to -1 and carries, so the all-+1
  // maximum wraps to all -1.
  function automatic pc_t pc_inc(input pc_t pc);
    pc_t  res;
    logic carry;
    res   = pc;
    carry = 1'b1;
    for (int i = 0; i < PC_TRITS; i++) begin
      if (carry) begin
        case (pc[i])
          T_NEG_ONE: begin res[i] = T_ZERO;    carry = 1'b0; end
          T_POS_ONE: begin res[i] = T_NEG_ONE; carry = 1'b1; end
          default:   begin res[i] = T_POS_ONE; carry = 1'b0; end
        endcase
      end
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  pc_t               fetch_pc_q, fetch_pc_d;
  pc_t               req_pc_q;
  logic              halt_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  pc_t               pc_mem    [QUEUE_DEPTH];
  instr_t            instr_mem [QUEUE_DEPTH];

  logic halting, full, pop, push, redirect_en;

  assign halting     = halt_q | halt_req;
  assign full        = (count_q == CNT_W'(QUEUE_DEPTH));
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  // HALT is terminal: redirects are ignored there.
  assign redirect_en = redirect_valid & (state_q != HALT);
  assign imem_req    = ~rst & (state_q == IDLE) & ~halting & ~full;
  assign imem_addr   = fetch_pc_q;
  // A response that coincides with a redirect belongs to the old stream.
  assign push        = (state_q == WAIT) & imem_rvalid & ~redirect_en;

  assign out_instr   = out_valid ? instr_mem[head_q] : '0;
  assign out_pc      = out_valid ? pc_mem[head_q]    : '0;
  assign halted      = (state_q == HALT);
  assign queue_count = count_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (imem_req)     state_d = WAIT;
        else if (halting) state_d = HALT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          fetch_pc_d = pc_inc(req_pc_q);
          state_d    = halting ? HALT : IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = halting ? HALT : IDLE;
      end
      default: state_d = HALT;
    endcase
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      // Any request still in flight (including one issued this cycle) must
      // have its response swallowed before fetching resumes.
      if ((state_q == WAIT && !imem_rvalid) || (state_q == IDLE && imem_req))
        state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      halt_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halting;
      if (imem_req) req_pc_q <= fetch_pc_q;
      if (redirect_en) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop)
          head_q <= (head_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : head_q + 1'b1;
        if (push)
          tail_q <= (tail_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= req_pc_q;
      instr_mem[tail_q] <= imem_rdata;
    end
  end

`ifdef TERNARY_FETCH_PERF_EN
  logic [31:0]      perf_fetches_q, perf_squashes_q;
  logic             discard;
  logic [CNT_W-1:0] flushed;

  assign discard = imem_rvalid & ((state_q == DRAIN) | ((state_q == WAIT) & redirect_en));
  // A head handed to decode in the redirect cycle counts as delivered.
  assign flushed = redirect_en ? (count_q - CNT_W'(pop)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches_q  <= '0;
      perf_squashes_q <= '0;
    end else begin
      if (push) perf_fetches_q <= perf_fetches_q + 32'd1;
      perf_squashes_q <= perf_squashes_q + 32'(discard) + 32'(flushed);
    end
  end

  assign perf_fetches  = perf_fetches_q;
  assign perf_squashes = perf_squashes_q;
`else
  assign perf_fetches  = '0;
  assign perf_squashes = '0;
`endif

endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Bench for ternary_fetch_unit: acts as instruction memory and decode, and
// keeps a transaction-level reference model (integer PCs, queues of expected
// entries and outstanding responses) that is compared against the DUT every
// cycle, plus directed scenarios for reset, backpressure, redirect, wrap,
// halt and reset during an outstanding fetch.
module tb_ternary_fetch_unit;
  import ternary_pkg::*;

  localparam int PC_TRITS    = 8;
  localparam int INSTR_TRITS = 9;
  localparam int QUEUE_DEPTH = 4;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);
  localparam int PC_MAX      = (3 ** PC_TRITS - 1) / 2;
  localparam int PW          = 2 * PC_TRITS;
  localparam int IW          = 2 * INSTR_TRITS;
  localparam int ENT_W       = PW + IW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       imem_req, imem_rvalid, out_valid, out_ready;
  logic                       redirect_valid, halt_req, halted;
  trit_t [PC_TRITS-1:0]       imem_addr, out_pc, redirect_pc;
  trit_t [INSTR_TRITS-1:0]    imem_rdata, out_instr;
  logic [CNT_W-1:0]           queue_count;
  logic [31:0]                perf_fetches, perf_squashes;
  logic [1:0]                 dbg_state;

  ternary_fetch_unit #(
    .PC_TRITS(PC_TRITS), .INSTR_TRITS(INSTR_TRITS), .QUEUE_DEPTH(QUEUE_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted),
    .queue_count(queue_count),
    .perf_fetches(perf_fetches), .perf_squashes(perf_squashes),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer -> balanced-ternary trit vector (2 bits per trit, LSB trit first).
  function automatic logic [63:0] bt(input int v);
    logic [63:0] t;
    int r, x;
    t = '0;
    x = v;
    for (int i = 0; i < 32; i++) begin
      r = x % 3;
      if (r == 2) r = -1;
      else if (r == -2) r = 1;
      t[2*i +: 2] = (r == 1) ? T_POS_ONE : (r == -1) ? T_NEG_ONE : T_ZERO;
      x = (x - r) / 3;
    end
    return t;
  endfunction

  function automatic logic [PW-1:0] pc_tr(input int v);
    logic [63:0] t;
    t = bt(v);
    return t[PW-1:0];
  endfunction

  function automatic logic [IW-1:0] in_tr(input int v);
    logic [63:0] t;
    t = bt(v);
    return t[IW-1:0];
  endfunction

  function automatic logic [ENT_W-1:0] ent(input int pc, input int val);
    return {pc_tr(pc), in_tr(val)};
  endfunction

  function automatic int pc_next(input int v);
    return (v == PC_MAX) ? -PC_MAX : v + 1;
  endfunction

  // ---------------- reference model state ----------------
  int               cyc = 0;
  int               m_next_pc = 0;
  int               m_count = 0;
  bit               m_halt_flag = 1'b0;
  bit               m_halted = 1'b0;
  logic [31:0]      m_fetch = '0;
  logic [31:0]      m_squash = '0;
  logic [ENT_W-1:0] exp_q[$];
  // Outstanding memory responses; kind 0 = live, 1 = squashed, 2 = killed by reset.
  int pend_pc[$], pend_val[$], pend_due[$], pend_kind[$];

  // Stimulus knobs read by tick().
  bit drv_rst = 1'b1, drv_ready = 1'b0, drv_redirect = 1'b0, drv_halt = 1'b0;
  int drv_redirect_pc = 0;
  int lat_lo = 1, lat_hi = 1;
  int salt = 0;

  // DUT observations.
  bit               dut_req_now;
  logic [PW-1:0]    dut_addr_now;
  logic [PW-1:0]    dut_addr_log[$];
  logic [ENT_W-1:0] dut_pop_log[$];
  int               full_req_cnt = 0;

  function automatic int live_pending();
    int n;
    n = 0;
    foreach (pend_kind[i]) if (pend_kind[i] != 2) n++;
    return n;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    bit req_exp, deliver, redir;
    int kind, dpc, dval;
    @(negedge clk);
    deliver        = (pend_due.size() > 0) && (pend_due[0] == cyc);
    rst            = drv_rst;
    imem_rvalid    = deliver;
    imem_rdata     = deliver ? in_tr(pend_val[0]) : '0;
    out_ready      = drv_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = pc_tr(drv_redirect_pc);
    halt_req       = drv_halt;
    #1;
    req_exp = !drv_rst && !(m_halt_flag || drv_halt) && (live_pending() == 0) &&
              (m_count < QUEUE_DEPTH);

    // scoreboard comparisons
    chk("queue_count", 64'(queue_count), 64'(m_count));
    chk("out_valid", 64'(out_valid), 64'(m_count > 0));
    if (m_count > 0) chk("head_entry", 64'({out_pc, out_instr}), 64'(exp_q[0]));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("imem_req", 64'(imem_req), 64'(req_exp));
    if (req_exp && imem_req) chk("imem_addr", 64'(imem_addr), 64'(pc_tr(m_next_pc)));
`ifdef TERNARY_FETCH_PERF_EN
    chk("perf_fetches", 64'(perf_fetches), 64'(m_fetch));
    chk("perf_squashes", 64'(perf_squashes), 64'(m_squash));
`else
    chk("perf_fetches_off", 64'(perf_fetches), 64'd0);
    chk("perf_squashes_off", 64'(perf_squashes), 64'd0);
`endif

    // observation logs
    dut_req_now  = imem_req;
    dut_addr_now = imem_addr;
    if (imem_req) dut_addr_log.push_back(imem_addr);
    if (out_valid && out_ready) dut_pop_log.push_back({out_pc, out_instr});
    if ((queue_count == CNT_W'(QUEUE_DEPTH)) && imem_req) full_req_cnt++;

    // model update for this edge
    if (drv_rst) begin
      foreach (pend_kind[i]) pend_kind[i] = 2;
      if (deliver) begin
        void'(pend_pc.pop_front()); void'(pend_val.pop_front());
        void'(pend_due.pop_front()); void'(pend_kind.pop_front());
      end
      exp_q.delete();
      m_count = 0; m_next_pc = 0; m_halt_flag = 0; m_halted = 0;
      m_fetch = '0; m_squash = '0;
    end else begin
      redir = drv_redirect && !m_halted;
      if ((m_count > 0) && drv_ready) begin
        void'(exp_q.pop_front());
        m_count--;
      end
      if (redir) begin
        m_squash += 32'(m_count);
        m_count = 0;
        exp_q.delete();
        foreach (pend_kind[i]) if (pend_kind[i] == 0) pend_kind[i] = 1;
      end
      if (req_exp) begin
        pend_pc.push_back(m_next_pc);
        pend_val.push_back(m_next_pc + salt);
        pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        pend_kind.push_back(redir ? 1 : 0);
      end
      if (redir) m_next_pc = drv_redirect_pc;
      if (deliver) begin
        dpc  = pend_pc.pop_front();
        dval = pend_val.pop_front();
        void'(pend_due.pop_front());
        kind = pend_kind.pop_front();
        if (kind == 0) begin
          exp_q.push_back(ent(dpc, dval));
          m_count++;
          m_fetch++;
          m_next_pc = pc_next(dpc);
        end else if (kind == 1) begin
          m_squash++;
        end
      end
      if (drv_halt) m_halt_flag = 1'b1;
      m_halted = m_halt_flag && (pend_pc.size() == 0);
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_redirect = 1'b0; drv_halt = 1'b0;
    repeat (4) tick();
    drv_rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dut_req_now) begin ok = 1'b1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_count"}, 64'(queue_count), 64'd0);
    chk({tag, "_perf_f"}, 64'(perf_fetches), 64'd0);
    chk({tag, "_perf_s"}, 64'(perf_squashes), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [ENT_W-1:0] snap[$];
  logic [PW-1:0]    all_neg;
  int               n0, nreq;
  bit               found;

  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    for (int i = 0; i < PC_TRITS; i++) all_neg[2*i +: 2] = T_NEG_ONE;

    // Reset state
    do_reset();
    reset_values("reset");

    // Reset fetch: 1-cycle memory, instr == PC
    lat_lo = 1; lat_hi = 1; drv_ready = 1'b1; salt = 0;
    dut_addr_log.delete(); dut_pop_log.delete();
    tick();
    chk("first_req_after_reset", 64'(dut_req_now), 64'd1);
    repeat (8) tick();
    chk("addr_log_len", 64'(dut_addr_log.size() >= 4), 64'd1);
    chk("pop_log_len", 64'(dut_pop_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < dut_addr_log.size(); i++)
      chk($sformatf("seq_addr_%0d", i), 64'(dut_addr_log[i]), 64'(pc_tr(i)));
    for (int i = 0; i < 4 && i < dut_pop_log.size(); i++)
      chk($sformatf("seq_pop_%0d", i), 64'(dut_pop_log[i]), 64'(ent(i, i)));
    n0 = dut_addr_log.size();
    repeat (20) tick();
    chk("throughput_1lat", 64'(dut_addr_log.size() - n0), 64'd10);

    // Backpressure: fill the queue, then drain in order
    lat_lo = 1; lat_hi = 2; drv_ready = 1'b0; full_req_cnt = 0;
    repeat (20) tick();
    chk("bp_full_count", 64'(queue_count), 64'(QUEUE_DEPTH));
    chk("bp_no_req_when_full", 64'(full_req_cnt), 64'd0);
    snap = exp_q;
    dut_pop_log.delete();
    drv_ready = 1'b1;
    repeat (12) tick();
    chk("bp_pop_len", 64'(dut_pop_log.size() >= QUEUE_DEPTH), 64'd1);
    for (int i = 0; i < QUEUE_DEPTH && i < dut_pop_log.size() && i < snap.size(); i++)
      chk($sformatf("bp_pop_%0d", i), 64'(dut_pop_log[i]), 64'(snap[i]));

    // Redirect with memory latency 3, one cycle after the request
    do_reset();
    lat_lo = 3; lat_hi = 3; drv_ready = 1'b1;
    wait_req("redir_first_req");
    drv_redirect = 1'b1; drv_redirect_pc = 5;
    tick();
    drv_redirect = 1'b0;
    wait_req("redir_next_req");
    chk("redir_addr", 64'(dut_addr_now), 64'(pc_tr(5)));
    chk("redir_queue_empty", 64'(queue_count), 64'd0);
`ifdef TERNARY_FETCH_PERF_EN
    chk("redir_perf_squashes", 64'(perf_squashes), 64'd1);
`else
    chk("redir_perf_squashes_off", 64'(perf_squashes), 64'd0);
`endif

    // Wrap-around: redirect to the all +1 PC, next sequential is all -1
    lat_lo = 1; lat_hi = 1;
    drv_redirect = 1'b1; drv_redirect_pc = PC_MAX;
    tick();
    drv_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut_req_now && (dut_addr_now == pc_tr(PC_MAX))) begin found = 1'b1; break; end
    end
    chk("wrap_max_req", 64'(found), 64'd1);
    wait_req("wrap_next_req");
    chk("wrap_addr", 64'(dut_addr_now), 64'(all_neg));

    // Halt while a request is outstanding (latency 2)
    do_reset();
    lat_lo = 2; lat_hi = 2; drv_ready = 1'b0;
    wait_req("halt_first_req");
    drv_halt = 1'b1;
    tick();
    drv_halt = 1'b0;
    repeat (2) tick();
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_enqueued", 64'(queue_count), 64'd1);
    chk("halt_head_pc", 64'(out_pc), 64'(pc_tr(0)));
    nreq = dut_addr_log.size();
    drv_redirect = 1'b1; drv_redirect_pc = 7;
    repeat (3) tick();
    drv_redirect = 1'b0;
    chk("halt_no_req", 64'(dut_addr_log.size() - nreq), 64'd0);
    chk("halt_queue_kept", 64'(queue_count), 64'd1);
    drv_ready = 1'b1;
    repeat (2) tick();
    chk("halt_drained", 64'(out_valid), 64'd0);
    chk("halt_still_halted", 64'(halted), 64'd1);

    // Reset while a request is outstanding; the stale response lands during reset
    do_reset();
    lat_lo = 3; lat_hi = 3; drv_ready = 1'b1;
    wait_req("rstwait_req");
    do_reset();
    reset_values("rstwait");
    tick();
    chk("rstwait_count", 64'(queue_count), 64'd0);
    chk("rstwait_req_again", 64'(dut_req_now), 64'd1);
    chk("rstwait_addr", 64'(dut_addr_now), 64'd0);

    // Randomised traffic checked against the model every cycle
    do_reset();
    salt = int'($urandom_range(3000, 0));
    for (int i = 0; i < 900; i++) begin
      lat_lo = 1; lat_hi = 3;
      drv_ready = ($urandom_range(9, 0) < 7);
      drv_redirect = ($urandom_range(19, 0) == 0);
      drv_redirect_pc = ($urandom_range(7, 0) == 0) ? PC_MAX
                        : int'($urandom_range(2 * PC_MAX, 0)) - PC_MAX;
      tick();
    end
    drv_redirect = 1'b0;
    drv_halt = 1'b1;
    tick();
    drv_halt = 1'b0;
    repeat (12) tick();
    chk("rand_final_halted", 64'(halted), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
